// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_pkg
//  Description : Shared FSM state type and default sizing for the push-button
//                debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        COUNT_HI  = 2'd1,
        STABLE_HI = 2'd2,
        COUNT_LO  = 2'd3
    } btn_state_e;

    localparam int BTN_NUM_DEFAULT      = 4;
    localparam int BTN_DEBOUNCE_DEFAULT = 1000000;
    localparam int BTN_LONG_DEFAULT     = 100000000;

endpackage : btn_pkg
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_channel
//  Description : One button: synchroniser, debounce FSM and, when
//                BTN_DEBOUNCE_LONGPRESS_EN is defined, a long-press detector.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = BTN_LONG_DEFAULT
) (
    input  logic clk_in,
    input  logic reset,
    input  logic raw_i,
    output logic clean_o,
    output logic press_o,
    output logic long_o
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 1) begin : g_param_check
        $error("debounce_channel: illegal parameter set");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_lvl;
    btn_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   clean_q;
    logic                   press_q;

    // Plain flop chain: nothing may sit between stages.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            press_q <= 1'b0;
            case (state_q)
                STABLE_LO: begin
                    cnt_q <= '0;
                    if (sync_lvl) begin
                        state_q <= COUNT_HI;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                COUNT_HI: begin
                    if (!sync_lvl) begin
                        state_q <= STABLE_LO;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_HI;
                        clean_q <= 1'b1;
                        press_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    cnt_q <= '0;
                    if (!sync_lvl) begin
                        state_q <= COUNT_LO;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                COUNT_LO: begin
                    if (sync_lvl) begin
                        state_q <= STABLE_HI;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= STABLE_LO;
                        clean_q <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= STABLE_LO;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign clean_o = clean_q;
    assign press_o = press_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
    localparam int               HOLD_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);

    logic [HOLD_W-1:0] hold_q;
    logic              long_q;

    // Saturation at HOLD_MAX is what limits the strobe to once per hold.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (state_q == STABLE_HI && sync_lvl) begin
                if (hold_q != HOLD_MAX) begin
                    hold_q <= hold_q + HOLD_W'(1);
                    long_q <= (hold_q == HOLD_MAX - HOLD_W'(1));
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : NUM_BTN independent synchronise-and-debounce channels.
//                Long-press strobes need BTN_DEBOUNCE_LONGPRESS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import btn_pkg::*;
#(
    parameter int NUM_BTN         = BTN_NUM_DEFAULT,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = BTN_LONG_DEFAULT
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_clean,
    output logic [NUM_BTN-1:0] btn_press_pulse,
    output logic [NUM_BTN-1:0] btn_long
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_chan (
            .clk_in  (clk_in),
            .reset   (reset),
            .raw_i   (btn_raw[i]),
            .clean_o (btn_clean[i]),
            .press_o (btn_press_pulse[i]),
            .long_o  (btn_long[i])
        );
    end

endmodule : button_debouncer
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debouncer
//  Description : Self-checking bench for button_debouncer against a
//                run-length reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam int NB  = 4;
    localparam int SS  = 2;
    localparam int DC  = 4;
    localparam int LC  = 10;
    localparam int LAT = SS + DC;

    logic          clk_in = 1'b0;
    logic          reset;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_clean;
    logic [NB-1:0] btn_press_pulse;
    logic [NB-1:0] btn_long;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .NUM_BTN         (NB),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC),
        .LONG_CYCLES     (LC)
    ) dut (
        .clk_in          (clk_in),
        .reset           (reset),
        .btn_raw         (btn_raw),
        .btn_clean       (btn_clean),
        .btn_press_pulse (btn_press_pulse),
        .btn_long        (btn_long)
    );

    always #5 clk_in = ~clk_in;

    // Reference: the level seen by the debouncer is btn_raw two samples late;
    // the clean level flips once DC consecutive seen samples disagree with it.
    logic [NB-1:0] m_d1, m_d2, m_clean, m_pulse, m_long;
    int            m_run  [NB];
    int            m_hold [NB];

    always @(posedge clk_in or posedge reset) begin : model
        bit s;
        if (reset) begin
            m_d1 = '0; m_d2 = '0; m_clean = '0; m_pulse = '0; m_long = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i]  = 0;
                m_hold[i] = 0;
            end
        end else begin
            for (int i = 0; i < NB; i++) begin
                s          = m_d2[i];
                m_pulse[i] = 1'b0;
                m_long[i]  = 1'b0;
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
                if (m_clean[i] && m_run[i] == 0 && s) begin
                    if (m_hold[i] < LC) begin
                        m_hold[i]++;
                        if (m_hold[i] == LC) m_long[i] = 1'b1;
                    end
                end else begin
                    m_hold[i] = 0;
                end
`endif
                if (s != m_clean[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC) begin
                        m_clean[i] = s;
                        m_pulse[i] = s;
                        m_run[i]   = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
    end

    task automatic test_reset();
        int lat;
        reset   = 1'b1;
        btn_raw = '1;
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        checks++;
        if ({btn_clean, btn_press_pulse, btn_long} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %b/%b/%b, want all zero", btn_clean, btn_press_pulse, btn_long);
        end
        reset = 1'b0;
        lat   = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in); #1;
            if (btn_clean == '1) begin lat = k; break; end
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL reset_release_latency: got %0d edges, want %0d", lat, LAT);
        end
        checks++;
        if (btn_press_pulse !== 4'b1111) begin
            errors++;
            $display("FAIL reset_release_pulse: got %b, want 1111", btn_press_pulse);
        end
        @(posedge clk_in); #1;
        checks++;
        if (btn_press_pulse !== 4'b0000 || btn_clean !== 4'b1111) begin
            errors++;
            $display("FAIL pulse_one_cycle: got pulse %b clean %b, want 0000 1111", btn_press_pulse, btn_clean);
        end
    endtask

    task automatic test_step();
        int lat, pulses;
        @(negedge clk_in); btn_raw = '0;
        repeat (12) @(negedge clk_in);
        btn_raw[0] = 1'b1;
        lat = -1; pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            if (btn_press_pulse[0]) pulses++;
            if (btn_clean[0] && lat < 0) lat = k;
        end
        checks++;
        if (lat != LAT || pulses != 1) begin
            errors++;
            $display("FAIL step_rise: got latency %0d pulses %0d, want %0d and 1", lat, pulses, LAT);
        end
        @(negedge clk_in); btn_raw[0] = 1'b0;
        lat = -1; pulses = 0;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            if (btn_press_pulse[0]) pulses++;
            if (!btn_clean[0] && lat < 0) lat = k;
        end
        checks++;
        if (lat != LAT || pulses != 0) begin
            errors++;
            $display("FAIL step_fall: got latency %0d pulses %0d, want %0d and 0", lat, pulses, LAT);
        end
    endtask

    task automatic test_glitch();
        bit pattern [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
        int seen_hi;
        seen_hi = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_in);
            btn_raw[1] = (k < 8) ? pattern[k] : 1'b0;
            @(posedge clk_in); #1;
            if (btn_clean[1] || btn_press_pulse[1]) seen_hi++;
            checks++;
            if ({btn_clean, btn_press_pulse, btn_long} !== {m_clean, m_pulse, m_long}) begin
                errors++;
                $display("FAIL glitch_model: got %b/%b/%b, want %b/%b/%b", btn_clean, btn_press_pulse, btn_long, m_clean, m_pulse, m_long);
            end
        end
        checks++;
        if (seen_hi != 0) begin
            errors++;
            $display("FAIL glitch_reject: got %0d cycles with clean/pulse high, want 0", seen_hi);
        end
    endtask

    task automatic test_simultaneous();
        int lat;
        @(negedge clk_in); btn_raw[3:2] = 2'b11;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            if (btn_clean[3:2] != 2'b00) begin lat = k; break; end
        end
        checks++;
        if (lat != LAT || btn_clean[3:2] !== 2'b11 || btn_press_pulse[3:2] !== 2'b11) begin
            errors++;
            $display("FAIL simultaneous: got latency %0d clean %b pulse %b, want %0d 11 11", lat, btn_clean[3:2], btn_press_pulse[3:2], LAT);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk_in); btn_raw[0] = 1'b1;
        repeat (4) @(posedge clk_in);
        @(negedge clk_in); reset = 1'b1;
        #1;
        checks++;
        if ({btn_clean, btn_press_pulse, btn_long} !== '0) begin
            errors++;
            $display("FAIL reset_async_clear: got %b/%b/%b, want all zero", btn_clean, btn_press_pulse, btn_long);
        end
        @(negedge clk_in); reset = 1'b0;
        lat = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk_in); #1;
            if (btn_clean[0]) begin lat = k; break; end
        end
        checks++;
        if (lat != LAT || btn_clean !== 4'b1101 || btn_press_pulse !== 4'b1101) begin
            errors++;
            $display("FAIL reset_mid_restart: got latency %0d clean %b pulse %b, want %0d 1101 1101", lat, btn_clean, btn_press_pulse, LAT);
        end
    endtask

    task automatic test_long();
        int rise, longs, first_long, exp_longs, exp_off;
        @(negedge clk_in); btn_raw = '0;
        repeat (12) @(negedge clk_in);
        btn_raw[0] = 1'b1;
        rise = -1; longs = 0; first_long = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in); #1;
            if (btn_press_pulse[0]) rise = k;
            if (btn_long[0]) begin
                longs++;
                if (first_long < 0) first_long = k;
            end
            checks++;
            if ({btn_clean, btn_press_pulse, btn_long} !== {m_clean, m_pulse, m_long}) begin
                errors++;
                $display("FAIL long_model: got %b/%b/%b, want %b/%b/%b", btn_clean, btn_press_pulse, btn_long, m_clean, m_pulse, m_long);
            end
        end
`ifdef BTN_DEBOUNCE_LONGPRESS_EN
        exp_longs = 1; exp_off = LC;
`else
        exp_longs = 0; exp_off = 0;
`endif
        checks++;
        if (longs != exp_longs || (exp_longs == 1 && first_long - rise != exp_off)) begin
            errors++;
            $display("FAIL long_press: got %0d strobes at offset %0d, want %0d at offset %0d", longs, first_long - rise, exp_longs, exp_off);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk_in);
            reset = ($urandom_range(299) == 0);
            for (int i = 0; i < NB; i++)
                if ($urandom_range(5) == 0) btn_raw[i] = ~btn_raw[i];
            @(posedge clk_in); #1;
            checks++;
            if ({btn_clean, btn_press_pulse, btn_long} !== {m_clean, m_pulse, m_long}) begin
                errors++;
                $display("FAIL random_model cyc %0d: got %b/%b/%b, want %b/%b/%b", k, btn_clean, btn_press_pulse, btn_long, m_clean, m_pulse, m_long);
            end
        end
        @(negedge clk_in); reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_glitch();
        test_simultaneous();
        test_reset_mid();
        test_long();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_button_debouncer
`default_nettype wire
